// File: rtl/reg_pipe_elastic_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : reg_pipe_elastic_pkg
//  Purpose  : Shared constants and types for the elastic pipeline register.
//             C_N is the default datapath width used across the datapath
//             blocks. stage_state_e encodes the per-stage occupancy FSM.
//  Revision : 1.0 - initial release
// ============================================================================
package reg_pipe_elastic_pkg;

  // Default datapath width shared by keyboard/ALU/display paths.
  localparam int unsigned C_N = 16;

  // Per-stage occupancy: EMPTY = no word, BUSY = main holds a word,
  // FULL = main and skid both hold a word.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    BUSY  = 2'b01,
    FULL  = 2'b10
  } stage_state_e;

endpackage : reg_pipe_elastic_pkg
`default_nettype wire

// File: rtl/reg_pipe_elastic_skid.sv
`default_nettype none
// ============================================================================
//  Module   : reg_skid_stage
//  Purpose  : One registered pipeline stage with a skid buffer. Holds up to
//             two words (main + skid) so that a stall seen at out_ready
//             never needs to propagate combinationally to in_ready.
//  Ports    : clk, reset (async, active-high), flush (sync clear)
//             in_valid / in_ready / in_data   - upstream handshake
//             out_valid / out_ready / out_data - downstream handshake
//  Revision : 1.0 - initial release
// ============================================================================
module reg_skid_stage
  import reg_pipe_elastic_pkg::*;
#(
  parameter int unsigned      WIDTH     = C_N,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  stage_state_e     state_q, state_d;
  logic [WIDTH-1:0] main_q,  main_d;
  logic [WIDTH-1:0] skid_q,  skid_d;
  logic             in_fire;
  logic             out_fire;

  // Both handshake outputs come straight from flops: no ready combinational
  // path through the stage, which is what lets stages chain without timing
  // paths growing with DEPTH.
  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
      main_d  = RESET_VAL;
      skid_d  = RESET_VAL;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_fire) begin
            main_d  = in_data;
            state_d = BUSY;
          end
        end
        BUSY: begin
          if (in_fire && out_fire) begin
            main_d = in_data;
          end else if (in_fire) begin
            // Downstream stalled: park the new word behind the current one.
            skid_d  = in_data;
            state_d = FULL;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          // in_ready is low here, so only the drain side can move.
          if (out_fire) begin
            main_d  = skid_q;
            state_d = BUSY;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
      main_q  <= RESET_VAL;
      skid_q  <= RESET_VAL;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule : reg_skid_stage
`default_nettype wire

// File: rtl/reg_pipe_elastic.sv
`default_nettype none
// ============================================================================
//  Module   : reg_pipe_elastic
//  Purpose  : DEPTH-stage elastic pipeline register with valid/ready on both
//             sides, synchronous flush and an occupancy counter. Each stage
//             is a reg_skid_stage, giving 2*DEPTH words of storage and full
//             throughput under back-pressure.
//  Ports    : clk, reset (async, active-high), flush (sync clear)
//             in_valid / in_ready / in_data    - upstream handshake
//             out_valid / out_ready / out_data - downstream handshake
//             count                            - words currently held
//  Revision : 1.0 - initial release
// ============================================================================
module reg_pipe_elastic
  import reg_pipe_elastic_pkg::*;
#(
  parameter int unsigned      WIDTH     = C_N,
  parameter int unsigned      DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           flush,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [WIDTH-1:0]               in_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [WIDTH-1:0]               out_data,
  output logic [$clog2(2*DEPTH+1)-1:0]   count
);

  localparam int unsigned CNT_W = $clog2(2*DEPTH+1);

  // Handshake links: index k is the input side of stage k; index DEPTH is
  // the pipeline output.
  logic [DEPTH:0]   link_valid;
  logic [DEPTH:0]   link_ready;
  logic [WIDTH-1:0] link_data [DEPTH+1];

  logic             top_in_fire;
  logic             top_out_fire;
  logic [CNT_W-1:0] count_q, count_d;

  assign link_valid[0] = in_valid;
  assign link_data[0]  = in_data;
  // Stage 0 may internally latch a word during flush, but flush also clears
  // it at the same edge; masking here keeps the upstream from seeing a fire.
  assign in_ready      = link_ready[0] & ~flush;

  assign out_valid         = link_valid[DEPTH];
  assign out_data          = link_data[DEPTH];
  assign link_ready[DEPTH] = out_ready;

  generate
    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
      reg_skid_stage #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
      ) u_stage (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (link_valid[k]),
        .in_ready  (link_ready[k]),
        .in_data   (link_data[k]),
        .out_valid (link_valid[k+1]),
        .out_ready (link_ready[k+1]),
        .out_data  (link_data[k+1])
      );
    end
  endgenerate

  assign top_in_fire  = in_valid & in_ready;
  assign top_out_fire = out_valid & out_ready;

  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else begin
      unique case ({top_in_fire, top_out_fire})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule : reg_pipe_elastic
`default_nettype wire

// File: tb/tb_reg_pipe_elastic.sv
`default_nettype none
// ============================================================================
//  Module   : tb_reg_pipe_elastic
//  Purpose  : Self-checking bench for reg_pipe_elastic (DEPTH=2). Accepted
//             words are pushed to a scoreboard queue and compared in order
//             as they leave the pipeline; occupancy is tracked by a model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_reg_pipe_elastic;

  localparam int          WIDTH = 16;
  localparam int          DEPTH = 2;
  localparam int          CW    = $clog2(2*DEPTH+1);
  localparam logic [15:0] RV    = 16'hA5C3;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [15:0]   in_data;
  logic          out_valid;
  logic          out_ready;
  logic [15:0]   out_data;
  logic [CW-1:0] count;

  always #5 clk = ~clk;

  reg_pipe_elastic #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .RESET_VAL (RV)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
  );

  logic [15:0] sb [$];
  int          mcount;
  int          exp_count;
  int          obs_count;
  logic        obs_in_ready;
  logic        obs_out_valid;
  int          checks = 0;
  int          errors = 0;

  // Drive one clock cycle starting just after a falling edge, sample the
  // handshake before the rising edge, update scoreboard/model, and return
  // at the next falling edge.
  task automatic cycle(input logic v, input logic r, input logic f,
                       input logic [15:0] d,
                       output logic in_f, output logic out_f,
                       output logic [15:0] od);
    in_valid  = v;
    out_ready = r;
    flush     = f;
    in_data   = d;
    #1;
    obs_in_ready  = in_ready;
    obs_out_valid = out_valid;
    obs_count     = int'(count);
    exp_count     = mcount;
    in_f  = v & in_ready;
    out_f = out_valid & r;
    od    = out_data;
    if (in_f) sb.push_back(d);
    mcount = f ? 0 : mcount + int'(in_f) - int'(out_f);
    @(posedge clk);
    @(negedge clk);
    if (f) sb.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    @(negedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++; if (count !== '0) begin errors++; $display("FAIL reset_count got=%0d want=0", count); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    checks++; if (out_data !== RV) begin errors++; $display("FAIL reset_out_data got=%h want=%h", out_data, RV); end
    flush = 1'b1; #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_flush_in_ready got=%b want=0", in_ready); end
    flush = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    mcount = 0;
  endtask

  task automatic test_drain(input string name);
    logic inf, outf;
    logic [15:0] od, exp;
    for (int c = 0; c < 20 && sb.size() > 0; c++) begin
      cycle(1'b0, 1'b1, 1'b0, 16'h0, inf, outf, od);
      if (outf) begin
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL %s_extra got=%h want=none", name, od); end
        else begin
          exp = sb.pop_front();
          if (od !== exp) begin errors++; $display("FAIL %s_data got=%h want=%h", name, od, exp); end
        end
      end
    end
    #1;
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL %s_left got=%0d words want=0", name, sb.size()); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL %s_out_valid got=%b want=0", name, out_valid); end
    checks++; if (count !== '0) begin errors++; $display("FAIL %s_count got=%0d want=0", name, count); end
  endtask

  task automatic test_stream();
    int sent = 0, got_n = 0, first_acc = -1, first_out = -1;
    logic inf, outf;
    logic [15:0] od, exp;
    for (int c = 0; c < 60 && got_n < 16; c++) begin
      cycle(sent < 16, 1'b1, 1'b0, 16'(sent + 1), inf, outf, od);
      if (inf) begin
        if (first_acc < 0) first_acc = c;
        sent++;
      end
      checks++;
      if (obs_count > DEPTH || obs_count != exp_count) begin
        errors++; $display("FAIL stream_count got=%0d want=%0d", obs_count, exp_count);
      end
      if (first_out >= 0) begin
        checks++;
        if (!outf) begin errors++; $display("FAIL stream_bubble got=0 want=1 at cycle %0d", c); end
      end
      if (outf) begin
        if (first_out < 0) first_out = c;
        got_n++;
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL stream_extra got=%h want=none", od); end
        else begin
          exp = sb.pop_front();
          if (od !== exp) begin errors++; $display("FAIL stream_data got=%h want=%h", od, exp); end
        end
      end
    end
    checks++;
    if (first_out - first_acc != DEPTH) begin
      errors++; $display("FAIL stream_latency got=%0d want=%0d", first_out - first_acc, DEPTH);
    end
    checks++; if (got_n != 16) begin errors++; $display("FAIL stream_delivered got=%0d want=16", got_n); end
  endtask

  task automatic test_full();
    int acc = 0;
    logic held_v = 1'b0;
    logic [15:0] held = '0;
    logic inf, outf;
    logic [15:0] od;
    for (int c = 0; c < 8; c++) begin
      cycle(1'b1, 1'b0, 1'b0, 16'(16'h0100 + acc), inf, outf, od);
      if (inf) acc++;
      checks++;
      if (obs_in_ready !== (c < 2*DEPTH)) begin
        errors++; $display("FAIL full_in_ready got=%b want=%b cycle %0d", obs_in_ready, (c < 2*DEPTH), c);
      end
      checks++;
      if (obs_count != exp_count) begin errors++; $display("FAIL full_count got=%0d want=%0d", obs_count, exp_count); end
      if (held_v) begin
        checks++;
        if (obs_out_valid !== 1'b1 || od !== held) begin
          errors++; $display("FAIL full_stable got=%b/%h want=1/%h", obs_out_valid, od, held);
        end
      end else if (obs_out_valid) begin
        held_v = 1'b1; held = od;
      end
    end
    checks++; if (acc != 2*DEPTH) begin errors++; $display("FAIL full_accepted got=%0d want=%0d", acc, 2*DEPTH); end
    #1;
    checks++; if (int'(count) != 2*DEPTH) begin errors++; $display("FAIL full_final_count got=%0d want=%0d", count, 2*DEPTH); end
    checks++; if (held !== 16'h0100) begin errors++; $display("FAIL full_head got=%h want=0100", held); end
  endtask

  task automatic test_toggle();
    int n = 0;
    logic inf, outf;
    logic [15:0] od, exp;
    for (int c = 0; c < 20; c++) begin
      cycle(1'b1, (c % 2) == 0, 1'b0, 16'(16'h0200 + n), inf, outf, od);
      if (inf) n++;
      checks++;
      if (obs_count < 3 || obs_count > 4 || obs_count != exp_count) begin
        errors++; $display("FAIL toggle_count got=%0d want=%0d (3..4)", obs_count, exp_count);
      end
      if (outf) begin
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL toggle_extra got=%h want=none", od); end
        else begin
          exp = sb.pop_front();
          if (od !== exp) begin errors++; $display("FAIL toggle_data got=%h want=%h", od, exp); end
        end
      end
    end
    test_drain("toggle_drain");
  endtask

  task automatic test_random();
    int sent = 0, got_n = 0;
    logic inf, outf;
    logic [15:0] od, exp;
    for (int c = 0; c < 70000 && got_n < 10000; c++) begin
      cycle((sent < 10000) && ($urandom_range(1) == 1), $urandom_range(1) == 1, 1'b0,
            16'($urandom), inf, outf, od);
      if (inf) sent++;
      checks++;
      if (obs_count != exp_count) begin errors++; $display("FAIL random_count got=%0d want=%0d", obs_count, exp_count); end
      if (outf) begin
        got_n++;
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL random_extra got=%h want=none", od); end
        else begin
          exp = sb.pop_front();
          if (od !== exp) begin errors++; $display("FAIL random_data got=%h want=%h", od, exp); end
        end
      end
    end
    checks++; if (got_n != 10000) begin errors++; $display("FAIL random_delivered got=%0d want=10000", got_n); end
    test_drain("random_drain");
  endtask

  task automatic test_flush();
    logic inf, outf;
    logic [15:0] od;
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 16'(16'h0300 + i), inf, outf, od);
    cycle(1'b1, 1'b0, 1'b1, 16'hDEAD, inf, outf, od);
    checks++; if (obs_in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready got=%b want=0", obs_in_ready); end
    checks++; if (obs_count != 3) begin errors++; $display("FAIL flush_pre_count got=%0d want=3", obs_count); end
    flush = 1'b0; in_valid = 1'b0; #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid got=%b want=0", out_valid); end
    checks++; if (count !== '0) begin errors++; $display("FAIL flush_count got=%0d want=0", count); end
    checks++; if (out_data !== RV) begin errors++; $display("FAIL flush_out_data got=%h want=%h", out_data, RV); end
    cycle(1'b1, 1'b1, 1'b0, 16'h0AAA, inf, outf, od);
    checks++; if (inf !== 1'b1) begin errors++; $display("FAIL flush_accept_after got=%b want=1", inf); end
    test_drain("flush_drain");
  endtask

  task automatic test_async_reset();
    logic inf, outf;
    logic [15:0] od;
    for (int i = 0; i < 2*DEPTH; i++) cycle(1'b1, 1'b0, 1'b0, 16'(16'h0400 + i), inf, outf, od);
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL areset_out_valid got=%b want=0", out_valid); end
    checks++; if (count !== '0) begin errors++; $display("FAIL areset_count got=%0d want=0", count); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL areset_in_ready got=%b want=1", in_ready); end
    checks++; if (out_data !== RV) begin errors++; $display("FAIL areset_out_data got=%h want=%h", out_data, RV); end
    sb.delete();
    mcount = 0;
    @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    cycle(1'b1, 1'b1, 1'b0, 16'h1234, inf, outf, od);
    checks++; if (inf !== 1'b1) begin errors++; $display("FAIL areset_accept got=%b want=1", inf); end
    test_drain("areset_drain");
  endtask

  initial begin
    mcount = 0;
    test_reset();
    test_stream();
    test_drain("stream_drain");
    test_full();
    test_toggle();
    test_random();
    test_flush();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_reg_pipe_elastic
`default_nettype wire
